mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//   Multicycle signed multiply/divide responder for the multicycle CPU datapath.
//   The control unit issues a one-cycle start with an op select.
//   The unit iterates one bit per cycle and pulses done.
//   The control unit then asserts hi_w/lo_w to copy hi_out/lo_out into HI/LO.
//   This block answers the control unit's requests; it never drives register-file or memory writes itself.
// PARAMETERS
//   WIDTH  32  operand width; product is 2*WIDTH, quotient/remainder are WIDTH each
// PORTS
//   clk       in   1      clock
//   reset     in   1      synchronous, active-high reset
//   start     in   1      request strobe; sampled only in IDLE
//   op        in   1      0 = MULT (signed), 1 = DIV (signed)
//   a         in   WIDTH  operand A (multiplicand / dividend), captured on accepted start
//   b         in   WIDTH  operand B (multiplier / divisor), captured on accepted start
//   busy      out  1      high from the cycle after start is accepted until done
//   done      out  1      one-cycle pulse; hi_out/lo_out are valid in that cycle
//   hi_out    out  WIDTH  MULT: product[2W-1:W]; DIV: remainder
//   lo_out    out  WIDTH  MULT: product[W-1:0];  DIV: quotient
//   div_zero  out  1      DIV with b==0; valid with done, held until next accepted start
// BEHAVIOUR
//   Reset:
//     - state=IDLE; busy=0, done=0, div_zero=0, hi_out=0, lo_out=0; iteration counter=0.
//     - Reset in any state, including mid-iteration, aborts the operation; no done is issued.
//   States: IDLE, MULT, DIV, FIX, DONE.
//   IDLE:
//     - start=1 captures |a|, |b|, the operand signs and op.
//     - Counter loads WIDTH-1; go to MULT or DIV; busy=1 next cycle.
//     - DIV with b==0 goes straight to DONE: div_zero=1, hi_out/lo_out unchanged.
//   MULT:
//     - Shift-add on magnitudes, one bit per cycle.
//     - Uses a 2W-bit accumulator; the adder is W+1 bits wide to keep the carry.
//   DIV:
//     - Restoring division on magnitudes, one quotient bit per cycle.
//     - Remainder register is W+1 bits wide.
//   Counter: decrements each cycle in MULT/DIV; at counter==0 go to FIX.
//   FIX:
//     - Applies sign and registers hi_out/lo_out.
//     - MULT: negate the 2W product if sign(a)^sign(b).
//     - DIV: quotient negated if sign(a)^sign(b), truncating toward zero.
//     - DIV: remainder takes the sign of the dividend.
//     - -2^(W-1) / -1: lo_out=0x80000000, hi_out=0 (two's-complement wrap, no flag).
//   DONE: done=1 and busy=0 for exactly one cycle; then IDLE.
//   Latency: start sampled at edge E -> done high in the cycle after edge E+WIDTH+1.
//     - i.e. WIDTH+2 cycles; 34 for WIDTH=32.
//     - Divide-by-zero: done high in the cycle after edge E+1.
//   Boundary conditions:
//     - start while busy or in DONE is ignored; no queueing.
//     - start in the same cycle done is high is ignored; the control unit waits one cycle.
//     - hi_out/lo_out hold their last results until the next FIX; they change only in FIX.
//     - Operands a/b may change after the start cycle without effect.
//     - Zero operands take full latency; there is no early exit.
// STRUCTURE
//   Shared header cpu_defs.vh holds:
//     - OP_MULT=1'b0, OP_DIV=1'b1;
//     - state encodings ST_MD_IDLE/MULT/DIV/FIX/DONE (3 bits);
//     - MD_LATENCY = WIDTH+2, used by the control unit and the bench.
//   One sub-module is natural: md_sign_fix.
//     - Conditional two's-complement negate of a 2W-bit value.
//     - Instantiated once for operand magnitude and reused in FIX via a mux.
//   Everything else is inline: one FSM always block plus one datapath always block.
// TESTING
//   MULT 7 * -3 -> done at cycle 34 after start; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high cycles 1..33.
//   MULT 0x7FFFFFFF * 0x7FFFFFFF -> hi=0x3FFFFFFF, lo=0x00000001.
//   DIV -7 / 2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); div_zero=0.
//   DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0; then DIV 5/0 -> done after 2 cycles, div_zero=1, hi/lo unchanged.
//   start pulsed again at cycle 10 of a MULT, and in the done cycle -> ignored; result equals the single-op result; one done pulse.
//   reset asserted at cycle 15 of a DIV -> next cycle busy=0, hi/lo=0, no done; new MULT 3*4 then gives lo=12, hi=0.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multicycle signed multiply/divide unit:
// operand width, op encodings, FSM state encodings and the fixed latency
// seen by the control unit.
package mult_div_unit_pkg;

   localparam int unsigned MD_WIDTH   = 32;
   localparam int unsigned MD_LATENCY = MD_WIDTH + 2;

   localparam logic OP_MULT = 1'b0;
   localparam logic OP_DIV  = 1'b1;

   typedef enum logic [2:0] {
      ST_MD_IDLE = 3'd0,
      ST_MD_MULT = 3'd1,
      ST_MD_DIV  = 3'd2,
      ST_MD_FIX  = 3'd3,
      ST_MD_DONE = 3'd4
   } md_state_e;

endpackage : mult_div_unit_pkg

// File: rtl/mult_div_unit_if.sv
// Request/response bundle between the control unit and the multiply/divide unit.
//   start, op, a, b                  : request (control unit -> unit)
//   busy, done, hi_out, lo_out,
//   div_zero                         : response (unit -> control unit)
interface mult_div_unit_if
   import mult_div_unit_pkg::*;
#(
   parameter int unsigned WIDTH = MD_WIDTH
);
   logic             start;
   logic             op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi_out;
   logic [WIDTH-1:0] lo_out;
   logic             div_zero;

   modport master (
      output start, op, a, b,
      input  busy, done, hi_out, lo_out, div_zero
   );

   modport slave (
      input  start, op, a, b,
      output busy, done, hi_out, lo_out, div_zero
   );
endinterface : mult_div_unit_if

// File: rtl/mult_div_unit_sign_fix.sv
// md_sign_fix: conditional two's-complement negate (combinational).
//   val_i  : value to fix
//   neg_i  : negate when high
//   res_c  : neg_i ? -val_i : val_i
module md_sign_fix #(
   parameter int unsigned W = 64
) (
   input  logic [W-1:0] val_i,
   input  logic         neg_i,
   output logic [W-1:0] res_c
);
   always_comb begin
      res_c = neg_i ? (~val_i + W'(1)) : val_i;
   end
endmodule : md_sign_fix

// File: rtl/mult_div_unit.sv
// mult_div_unit: multicycle signed MULT/DIV, one bit per cycle on operand
// magnitudes, sign applied in FIX. Results hold until the next FIX.
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave side of mult_div_unit_if (start/op/a/b in;
//                busy/done/hi_out/lo_out/div_zero out)
module mult_div_unit
   import mult_div_unit_pkg::*;
#(
   parameter int unsigned WIDTH = MD_WIDTH
) (
   input  logic           clk,
   input  logic           reset,
   mult_div_unit_if.slave bus
);
   localparam int unsigned CNT_W = $clog2(WIDTH);
   localparam int unsigned PW    = 2 * WIDTH;

   md_state_e        state_q, state_d;
   logic             busy_q, busy_d, done_q, done_d, dz_q, dz_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             op_q, op_d, sa_q, sa_d, sb_q, sb_d;
   logic [WIDTH-1:0] am_q, am_d, bm_q, bm_d;
   logic [PW-1:0]    acc_q, acc_d;   // MULT: {hi, lo}; DIV: lo shifts dividend out, quotient in
   logic [WIDTH:0]   rem_q, rem_d;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

   logic             accept_c, fix_neg_c, ge_c;
   logic [PW-1:0]    fix_in_c, fix_res_c;
   logic [WIDTH:0]   sum_c, shl_c, diff_c;
   logic [WIDTH-1:0] b_abs_c, rem_fix_c;

   // One negator: |a| while idle, signed result in FIX
   md_sign_fix #(.W(PW)) u_sign_fix (
      .val_i (fix_in_c),
      .neg_i (fix_neg_c),
      .res_c (fix_res_c)
   );

   // Next state and registered status outputs
   always_comb begin
      state_d  = state_q;
      accept_c = 1'b0;
      case (state_q)
         ST_MD_IDLE: begin
            if (bus.start) begin
               accept_c = 1'b1;
               state_d  = (bus.op == OP_DIV) ? ST_MD_DIV : ST_MD_MULT;
            end
         end
         ST_MD_MULT: if (cnt_q == '0) state_d = ST_MD_FIX;
         ST_MD_DIV: begin
            if (bm_q == '0)       state_d = ST_MD_DONE;
            else if (cnt_q == '0) state_d = ST_MD_FIX;
         end
         ST_MD_FIX:  state_d = ST_MD_DONE;
         ST_MD_DONE: state_d = ST_MD_IDLE;
         default:    state_d = ST_MD_IDLE;
      endcase
      busy_d = (state_d == ST_MD_MULT) || (state_d == ST_MD_DIV) || (state_d == ST_MD_FIX);
      done_d = (state_d == ST_MD_DONE);
   end

   // Datapath next values
   always_comb begin
      cnt_d = cnt_q;
      op_d  = op_q;
      sa_d  = sa_q;
      sb_d  = sb_q;
      am_d  = am_q;
      bm_d  = bm_q;
      acc_d = acc_q;
      rem_d = rem_q;
      hi_d  = hi_q;
      lo_d  = lo_q;
      dz_d  = dz_q;

      fix_in_c  = {{WIDTH{bus.a[WIDTH-1]}}, bus.a};
      fix_neg_c = bus.a[WIDTH-1];
      if (state_q == ST_MD_FIX) begin
         fix_in_c  = (op_q == OP_MULT) ? acc_q : PW'(acc_q[WIDTH-1:0]);
         fix_neg_c = sa_q ^ sb_q;
      end

      b_abs_c   = bus.b[WIDTH-1] ? (~bus.b + WIDTH'(1)) : bus.b;
      // Remainder follows the dividend's sign; its top bit is always clear here
      rem_fix_c = sa_q ? (~WIDTH'(rem_q) + WIDTH'(1)) : WIDTH'(rem_q);
      // W+1-bit adder keeps the carry of each partial sum
      sum_c     = {1'b0, acc_q[PW-1:WIDTH]} + {1'b0, am_q};
      shl_c     = {rem_q[WIDTH-1:0], acc_q[WIDTH-1]};
      ge_c      = (shl_c >= {1'b0, bm_q});
      diff_c    = shl_c - {1'b0, bm_q};

      case (state_q)
         ST_MD_IDLE: begin
            if (accept_c) begin
               cnt_d = CNT_W'(WIDTH - 1);
               op_d  = bus.op;
               sa_d  = bus.a[WIDTH-1];
               sb_d  = bus.b[WIDTH-1];
               am_d  = fix_res_c[WIDTH-1:0];
               bm_d  = b_abs_c;
               acc_d = {WIDTH'(0), (bus.op == OP_DIV) ? fix_res_c[WIDTH-1:0] : b_abs_c};
               rem_d = '0;
               dz_d  = 1'b0;
            end
         end
         ST_MD_MULT: begin
            cnt_d = cnt_q - CNT_W'(1);
            acc_d = acc_q[0] ? {sum_c, acc_q[WIDTH-1:1]} : {1'b0, acc_q[PW-1:1]};
         end
         ST_MD_DIV: begin
            if (bm_q == '0) begin
               dz_d = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
               rem_d = ge_c ? diff_c : shl_c;
               acc_d = {acc_q[PW-1:WIDTH], acc_q[WIDTH-2:0], ge_c};
            end
         end
         ST_MD_FIX: begin
            if (op_q == OP_MULT) begin
               hi_d = fix_res_c[PW-1:WIDTH];
               lo_d = fix_res_c[WIDTH-1:0];
            end else begin
               hi_d = rem_fix_c;
               lo_d = fix_res_c[WIDTH-1:0];
            end
         end
         default: ;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_MD_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dz_q    <= 1'b0;
         cnt_q   <= '0;
         op_q    <= OP_MULT;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         am_q    <= '0;
         bm_q    <= '0;
         acc_q   <= '0;
         rem_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         dz_q    <= dz_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         am_q    <= am_d;
         bm_q    <= bm_d;
         acc_q   <= acc_d;
         rem_q   <= rem_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.div_zero = dz_q;
   assign bus.hi_out   = hi_q;
   assign bus.lo_out   = lo_q;

endmodule : mult_div_unit

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit: reset values, signed MULT
// and DIV results, latency, busy window, divide-by-zero, ignored starts and
// mid-operation reset.
module tb_mult_div_unit;
   import mult_div_unit_pkg::*;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   mult_div_unit_if #(.WIDTH(32)) md_if ();

   mult_div_unit #(.WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (md_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issue one op; returns with time in the done cycle (or after a 100-cycle bound).
   // lat = cycle index of done (cycle 1 = first cycle after the accepting edge), 0 if none.
   task automatic run_op(input logic op_v, input logic [31:0] a_v, input logic [31:0] b_v,
                         input int restart_at, output int lat, output int busy_n);
      @(posedge clk); #1;
      md_if.start = 1'b1;
      md_if.op    = op_v;
      md_if.a     = a_v;
      md_if.b     = b_v;
      @(posedge clk); #1;
      md_if.start = 1'b0;
      md_if.op    = ~op_v;
      md_if.a     = 32'hDEAD_BEEF;
      md_if.b     = 32'h0000_0000;
      lat    = 0;
      busy_n = 0;
      for (int c = 1; c <= 100; c++) begin
         if (md_if.done === 1'b1) begin
            lat = c;
            break;
         end
         if (md_if.busy === 1'b1) busy_n++;
         md_if.start = (c == restart_at);
         @(posedge clk); #1;
      end
      md_if.start = 1'b0;
   endtask

   task automatic test_reset();
      reset       = 1'b1;
      md_if.start = 1'b0;
      md_if.op    = OP_MULT;
      md_if.a     = '0;
      md_if.b     = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (md_if.busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b expected 0", md_if.busy); end
      checks++; if (md_if.done !== 1'b0) begin errors++; $display("FAIL reset done: got %b expected 0", md_if.done); end
      checks++; if (md_if.div_zero !== 1'b0) begin errors++; $display("FAIL reset div_zero: got %b expected 0", md_if.div_zero); end
      checks++; if (md_if.hi_out !== 32'h0) begin errors++; $display("FAIL reset hi_out: got %h expected 00000000", md_if.hi_out); end
      checks++; if (md_if.lo_out !== 32'h0) begin errors++; $display("FAIL reset lo_out: got %h expected 00000000", md_if.lo_out); end
      reset = 1'b0;
   endtask

   task automatic test_mult();
      int lat, bn;
      run_op(OP_MULT, 32'd7, 32'hFFFF_FFFD, 0, lat, bn);
      checks++; if (lat != 34) begin errors++; $display("FAIL mult_7x-3 latency: got %0d expected 34", lat); end
      checks++; if (bn != 33) begin errors++; $display("FAIL mult_7x-3 busy cycles: got %0d expected 33", bn); end
      checks++; if (md_if.busy !== 1'b0) begin errors++; $display("FAIL mult_7x-3 busy in done: got %b expected 0", md_if.busy); end
      checks++; if (md_if.hi_out !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_7x-3 hi: got %h expected ffffffff", md_if.hi_out); end
      checks++; if (md_if.lo_out !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mult_7x-3 lo: got %h expected ffffffeb", md_if.lo_out); end
      checks++; if (md_if.div_zero !== 1'b0) begin errors++; $display("FAIL mult_7x-3 div_zero: got %b expected 0", md_if.div_zero); end
      @(posedge clk); #1;
      checks++; if (md_if.done !== 1'b0) begin errors++; $display("FAIL mult_7x-3 done width: got %b expected 0", md_if.done); end

      run_op(OP_MULT, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0, lat, bn);
      checks++; if (md_if.hi_out !== 32'h3FFF_FFFF) begin errors++; $display("FAIL mult_max hi: got %h expected 3fffffff", md_if.hi_out); end
      checks++; if (md_if.lo_out !== 32'h0000_0001) begin errors++; $display("FAIL mult_max lo: got %h expected 00000001", md_if.lo_out); end

      // Zero operand: full latency, result zero even with negative other operand
      run_op(OP_MULT, 32'h0, 32'hFFFF_FFF7, 0, lat, bn);
      checks++; if (lat != 34) begin errors++; $display("FAIL mult_zero latency: got %0d expected 34", lat); end
      checks++; if (md_if.hi_out !== 32'h0) begin errors++; $display("FAIL mult_zero hi: got %h expected 00000000", md_if.hi_out); end
      checks++; if (md_if.lo_out !== 32'h0) begin errors++; $display("FAIL mult_zero lo: got %h expected 00000000", md_if.lo_out); end
   endtask

   task automatic test_div();
      int lat, bn;
      run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, lat, bn);
      checks++; if (lat != 34) begin errors++; $display("FAIL div_-7/2 latency: got %0d expected 34", lat); end
      checks++; if (md_if.lo_out !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_-7/2 quotient: got %h expected fffffffd", md_if.lo_out); end
      checks++; if (md_if.hi_out !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_-7/2 remainder: got %h expected ffffffff", md_if.hi_out); end
      checks++; if (md_if.div_zero !== 1'b0) begin errors++; $display("FAIL div_-7/2 div_zero: got %b expected 0", md_if.div_zero); end

      run_op(OP_DIV, 32'd100, 32'hFFFF_FFF9, 0, lat, bn);
      checks++; if (md_if.lo_out !== 32'hFFFF_FFF2) begin errors++; $display("FAIL div_100/-7 quotient: got %h expected fffffff2", md_if.lo_out); end
      checks++; if (md_if.hi_out !== 32'h0000_0002) begin errors++; $display("FAIL div_100/-7 remainder: got %h expected 00000002", md_if.hi_out); end
   endtask

   task automatic test_div_boundary();
      int lat, bn;
      run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, lat, bn);
      checks++; if (lat != 34) begin errors++; $display("FAIL div_ovf latency: got %0d expected 34", lat); end
      checks++; if (md_if.lo_out !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf quotient: got %h expected 80000000", md_if.lo_out); end
      checks++; if (md_if.hi_out !== 32'h0) begin errors++; $display("FAIL div_ovf remainder: got %h expected 00000000", md_if.hi_out); end

      run_op(OP_DIV, 32'd5, 32'h0, 0, lat, bn);
      checks++; if (lat != 2) begin errors++; $display("FAIL div_zero latency: got %0d expected 2", lat); end
      checks++; if (bn != 1) begin errors++; $display("FAIL div_zero busy cycles: got %0d expected 1", bn); end
      checks++; if (md_if.div_zero !== 1'b1) begin errors++; $display("FAIL div_zero flag: got %b expected 1", md_if.div_zero); end
      checks++; if (md_if.lo_out !== 32'h8000_0000) begin errors++; $display("FAIL div_zero lo held: got %h expected 80000000", md_if.lo_out); end
      checks++; if (md_if.hi_out !== 32'h0) begin errors++; $display("FAIL div_zero hi held: got %h expected 00000000", md_if.hi_out); end
      repeat (3) begin @(posedge clk); #1; end
      checks++; if (md_if.div_zero !== 1'b1) begin errors++; $display("FAIL div_zero flag hold: got %b expected 1", md_if.div_zero); end
   endtask

   task automatic test_back_to_back();
      int lat, bn, extra_done, extra_busy;
      // -5 * 6 = -30 with a stray start in cycle 10 and in the done cycle
      run_op(OP_MULT, 32'hFFFF_FFFB, 32'd6, 10, lat, bn);
      checks++; if (lat != 34) begin errors++; $display("FAIL b2b latency: got %0d expected 34", lat); end
      checks++; if (bn != 33) begin errors++; $display("FAIL b2b busy cycles: got %0d expected 33", bn); end
      checks++; if (md_if.hi_out !== 32'hFFFF_FFFF) begin errors++; $display("FAIL b2b hi: got %h expected ffffffff", md_if.hi_out); end
      checks++; if (md_if.lo_out !== 32'hFFFF_FFE2) begin errors++; $display("FAIL b2b lo: got %h expected ffffffe2", md_if.lo_out); end
      checks++; if (md_if.div_zero !== 1'b0) begin errors++; $display("FAIL b2b div_zero cleared: got %b expected 0", md_if.div_zero); end
      md_if.start = 1'b1;
      md_if.op    = OP_MULT;
      md_if.a     = 32'd1;
      md_if.b     = 32'd1;
      @(posedge clk); #1;
      md_if.start = 1'b0;
      extra_done = 0;
      extra_busy = 0;
      for (int c = 0; c < 40; c++) begin
         if (md_if.done === 1'b1) extra_done++;
         if (md_if.busy === 1'b1) extra_busy++;
         @(posedge clk); #1;
      end
      checks++; if (extra_done != 0) begin errors++; $display("FAIL b2b extra done pulses: got %0d expected 0", extra_done); end
      checks++; if (extra_busy != 0) begin errors++; $display("FAIL b2b extra busy cycles: got %0d expected 0", extra_busy); end
      checks++; if (md_if.lo_out !== 32'hFFFF_FFE2) begin errors++; $display("FAIL b2b lo held: got %h expected ffffffe2", md_if.lo_out); end
   endtask

   task automatic test_reset_mid_op();
      int lat, bn, stray;
      @(posedge clk); #1;
      md_if.start = 1'b1;
      md_if.op    = OP_DIV;
      md_if.a     = 32'd100;
      md_if.b     = 32'd7;
      @(posedge clk); #1;
      md_if.start = 1'b0;
      repeat (14) begin @(posedge clk); #1; end
      checks++; if (md_if.busy !== 1'b1) begin errors++; $display("FAIL rst_mid busy before: got %b expected 1", md_if.busy); end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      checks++; if (md_if.busy !== 1'b0) begin errors++; $display("FAIL rst_mid busy: got %b expected 0", md_if.busy); end
      checks++; if (md_if.done !== 1'b0) begin errors++; $display("FAIL rst_mid done: got %b expected 0", md_if.done); end
      checks++; if (md_if.hi_out !== 32'h0) begin errors++; $display("FAIL rst_mid hi: got %h expected 00000000", md_if.hi_out); end
      checks++; if (md_if.lo_out !== 32'h0) begin errors++; $display("FAIL rst_mid lo: got %h expected 00000000", md_if.lo_out); end
      stray = 0;
      for (int c = 0; c < 40; c++) begin
         if (md_if.done === 1'b1) stray++;
         @(posedge clk); #1;
      end
      checks++; if (stray != 0) begin errors++; $display("FAIL rst_mid stray done: got %0d expected 0", stray); end
      run_op(OP_MULT, 32'd3, 32'd4, 0, lat, bn);
      checks++; if (lat != 34) begin errors++; $display("FAIL rst_mid mult latency: got %0d expected 34", lat); end
      checks++; if (md_if.lo_out !== 32'd12) begin errors++; $display("FAIL rst_mid mult lo: got %h expected 0000000c", md_if.lo_out); end
      checks++; if (md_if.hi_out !== 32'h0) begin errors++; $display("FAIL rst_mid mult hi: got %h expected 00000000", md_if.hi_out); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_mult();
      test_div();
      test_div_boundary();
      test_back_to_back();
      test_reset_mid_op();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_mult_div_unit
